// File: rtl/pipe_pkg.sv
// Shared types for the hazard/forwarding controller:
// operand selects, shadow slot, memory-wait FSM states.
package pipe_pkg;

   localparam int RA_MAX = 8;

   typedef enum logic [1:0] {
      FWD_ID  = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_t;

   typedef struct packed {
      logic              valid;
      logic [RA_MAX-1:0] rd;
      logic              we;
      logic              load;
   } slot_t;

   typedef enum logic {
      RUN   = 1'b0,
      MWAIT = 1'b1
   } fsm_state_t;

   localparam slot_t SLOT_NONE = '0;

   function automatic logic hz_src(slot_t s);
      return s.valid & s.we & (s.rd != '0);
   endfunction

   function automatic logic hits(
      slot_t s, logic [RA_MAX-1:0] a
   );
      return hz_src(s) & (s.rd == a);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID decode fields in, pipeline controls out.
// Counter signals exist only with HAZARD_PERF_CNT_EN.
interface hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_use_rs;
   logic              id_use_rt;
   logic [REG_AW-1:0] id_rd;
   logic              id_we;
   logic              id_is_load;
   logic              ex_branch_taken;
   logic              pc_en;
   logic              ifid_en;
   logic              idex_bubble;
   logic              ifid_flush;
   logic              mem_freeze;
   logic [1:0]        fwd_rs_sel;
   logic [1:0]        fwd_rt_sel;
   logic              id_rs_byp;
   logic              id_rt_byp;
`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output id_valid, id_rs, id_rt,
      output id_use_rs, id_use_rt,
      output id_rd, id_we, id_is_load,
      output ex_branch_taken,
      input  pc_en, ifid_en, idex_bubble,
      input  ifid_flush, mem_freeze,
      input  fwd_rs_sel, fwd_rt_sel,
      input  id_rs_byp, id_rt_byp,
      input  stall_cnt, flush_cnt
   );
   modport slave (
      input  id_valid, id_rs, id_rt,
      input  id_use_rs, id_use_rt,
      input  id_rd, id_we, id_is_load,
      input  ex_branch_taken,
      output pc_en, ifid_en, idex_bubble,
      output ifid_flush, mem_freeze,
      output fwd_rs_sel, fwd_rt_sel,
      output id_rs_byp, id_rt_byp,
      output stall_cnt, flush_cnt
   );
`else
   localparam int unused_cnt_w = CNT_W;

   modport master (
      output id_valid, id_rs, id_rt,
      output id_use_rs, id_use_rt,
      output id_rd, id_we, id_is_load,
      output ex_branch_taken,
      input  pc_en, ifid_en, idex_bubble,
      input  ifid_flush, mem_freeze,
      input  fwd_rs_sel, fwd_rt_sel,
      input  id_rs_byp, id_rt_byp
   );
   modport slave (
      input  id_valid, id_rs, id_rt,
      input  id_use_rs, id_use_rt,
      input  id_rd, id_we, id_is_load,
      input  ex_branch_taken,
      output pc_en, ifid_en, idex_bubble,
      output ifid_flush, mem_freeze,
      output fwd_rs_sel, fwd_rt_sel,
      output id_rs_byp, id_rt_byp
   );
`endif
endinterface

// File: rtl/hz_mem_wait.sv
// RUN/MWAIT freeze FSM: a start pulse with lat_i > 1
// freezes the pipeline for lat_i-1 cycles.
module hz_mem_wait
   import pipe_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [3:0] lat_i,
   output logic       freeze_o
);

   fsm_state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      freeze_o = 1'b0;
      unique case (state_q)
         RUN: begin
            if (start_i && lat_i > 4'd1) begin
               state_d = MWAIT;
               cnt_d   = lat_i - 4'd2;
            end
         end
         MWAIT: begin
            freeze_o = 1'b1;
            if (cnt_q == 4'd0) state_d = RUN;
            else cnt_d = cnt_q - 4'd1;
         end
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller shadowing EX/MEM/WB.
// Define HAZARD_PERF_CNT_EN for stall/flush counters.
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_AW  = 5,
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 32
) (
   input logic   clk,
   input logic   rst,
   hazard_ctrl_if.slave hz
);

   slot_t    s_ex_q, s_ex_d, s_mem_q, s_wb_q;
   fwd_sel_t fwd_rs_q, fwd_rs_d;
   fwd_sel_t fwd_rt_q, fwd_rt_d;

   logic [RA_MAX-1:0] rs_a, rt_a, rd_a;
   logic freeze, brk, ldu, bubble, pc_en;
   logic unused_wb_ld;

   assign rs_a = RA_MAX'(hz.id_rs);
   assign rt_a = RA_MAX'(hz.id_rt);
   assign rd_a = RA_MAX'(hz.id_rd);
   assign unused_wb_ld = s_wb_q.load;

   hz_mem_wait u_mw (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (s_mem_q.valid & s_mem_q.load),
      .lat_i    (4'(MEM_LAT)),
      .freeze_o (freeze)
   );

   // Freeze outranks a branch, which outranks a load-use stall.
   assign brk = hz.ex_branch_taken & ~freeze;
   assign ldu = ~freeze & ~brk & hz.id_valid
              & s_ex_q.load
              & ((hz.id_use_rs & hits(s_ex_q, rs_a))
              |  (hz.id_use_rt & hits(s_ex_q, rt_a)));
   assign bubble = ~freeze & (brk | ldu);
   assign pc_en  = ~freeze & ~ldu;

   assign hz.pc_en       = pc_en;
   assign hz.ifid_en     = pc_en;
   assign hz.idex_bubble = bubble;
   assign hz.ifid_flush  = brk;
   assign hz.mem_freeze  = freeze;
   assign hz.id_rs_byp   = hits(s_wb_q, rs_a);
   assign hz.id_rt_byp   = hits(s_wb_q, rt_a);
   assign hz.fwd_rs_sel  = fwd_rs_q;
   assign hz.fwd_rt_sel  = fwd_rt_q;

   function automatic fwd_sel_t pick(
      logic v, logic [RA_MAX-1:0] a
   );
      fwd_sel_t r;
      r = FWD_ID;
      if (v && !s_ex_q.load && hits(s_ex_q, a))
         r = FWD_MEM;
      else if (v && hits(s_mem_q, a))
         r = FWD_WB;
      return r;
   endfunction

   always_comb begin
      s_ex_d   = SLOT_NONE;
      fwd_rs_d = FWD_ID;
      fwd_rt_d = FWD_ID;
      if (hz.id_valid && !bubble) begin
         s_ex_d.valid = 1'b1;
         s_ex_d.rd    = rd_a;
         s_ex_d.we    = hz.id_we;
         s_ex_d.load  = hz.id_is_load;
         fwd_rs_d = pick(hz.id_use_rs, rs_a);
         fwd_rt_d = pick(hz.id_use_rt, rt_a);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_ex_q   <= SLOT_NONE;
         s_mem_q  <= SLOT_NONE;
         s_wb_q   <= SLOT_NONE;
         fwd_rs_q <= FWD_ID;
         fwd_rt_q <= FWD_ID;
      end else if (!freeze) begin
         s_wb_q   <= s_mem_q;
         s_mem_q  <= s_ex_q;
         s_ex_q   <= s_ex_d;
         fwd_rs_q <= fwd_rs_d;
         fwd_rt_q <= fwd_rt_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q, flush_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_en) stall_q <= stall_q + CNT_W'(1);
         if (brk)    flush_q <= flush_q + CNT_W'(1);
      end
   end

   assign hz.stall_cnt = stall_q;
   assign hz.flush_cnt = flush_q;
`else
   localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MEM_LAT=4):
// in-flight model predicts, negedge monitor compares.
module tb_hazard_ctrl;

   localparam int LAT = 4;
   localparam int CW  = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.REG_AW(5), .CNT_W(CW)) bus ();

   hazard_ctrl #(
      .REG_AW(5), .MEM_LAT(LAT), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .hz(bus)
   );

   typedef struct {
      bit v; int rd; bit we; bit ld;
   } ins_t;

   typedef struct packed {
      logic pc, ifid, bub, fl, frz, brs, brt;
      logic [1:0] frs, frt;
      logic [CW-1:0] sc, fc;
   } obs_t;

   // Instructions past ID: [0]=EX, [1]=MEM, [2]=WB.
   ins_t pipe [3];
   int   frz_left;
   logic [1:0] m_frs, m_frt;
   int   m_sc, m_fc;
   obs_t q [$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   function automatic bit prod(ins_t s);
      return s.v && s.we && s.rd != 0;
   endfunction

   function automatic logic [1:0] fsel(
      bit v, bit u, int src
   );
      if (!(v && u)) return 2'd0;
      if (prod(pipe[0]) && !pipe[0].ld
          && pipe[0].rd == src) return 2'd1;
      if (prod(pipe[1]) && pipe[1].rd == src)
         return 2'd2;
      return 2'd0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++)
         pipe[i] = '{0, 0, 0, 0};
      frz_left = 0;
      m_frs = 0; m_frt = 0;
      m_sc = 0; m_fc = 0;
   endtask

   task automatic tick(
      input bit r, v,
      input int rs, rt,
      input bit urs, urt,
      input int rd,
      input bit we, ld, br
   );
      obs_t e;
      bit frozen, b, lu;
      logic [1:0] nrs, nrt;
      @(posedge clk); #1;
      rst = r;
      bus.id_valid = v;
      bus.id_rs = 5'(rs);
      bus.id_rt = 5'(rt);
      bus.id_use_rs = urs;
      bus.id_use_rt = urt;
      bus.id_rd = 5'(rd);
      bus.id_we = we;
      bus.id_is_load = ld;
      bus.ex_branch_taken = br;
      frozen = frz_left > 0;
      b  = br && !frozen;
      lu = !frozen && !b && v && pipe[0].ld
         && prod(pipe[0])
         && ((urs && pipe[0].rd == rs)
          || (urt && pipe[0].rd == rt));
      e.pc   = !frozen && !lu;
      e.ifid = !frozen && !lu;
      e.bub  = !frozen && (b || lu);
      e.fl   = b;
      e.frz  = frozen;
      e.brs  = prod(pipe[2]) && pipe[2].rd == rs;
      e.brt  = prod(pipe[2]) && pipe[2].rd == rt;
      e.frs  = m_frs;
      e.frt  = m_frt;
`ifdef HAZARD_PERF_CNT_EN
      e.sc = CW'(m_sc);
      e.fc = CW'(m_fc);
`else
      e.sc = '0;
      e.fc = '0;
`endif
      q.push_back(e);
      if (r) model_reset();
      else begin
         if (!e.pc) m_sc++;
         if (b) m_fc++;
         if (frozen) frz_left--;
         else begin
            if (pipe[1].v && pipe[1].ld && LAT > 1)
               frz_left = LAT - 1;
            nrs = e.bub ? 2'd0 : fsel(v, urs, rs);
            nrt = e.bub ? 2'd0 : fsel(v, urt, rt);
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (v && !e.bub) pipe[0] = '{1, rd, we, ld};
            else pipe[0] = '{0, 0, 0, 0};
            m_frs = nrs;
            m_frt = nrt;
         end
      end
   endtask

   task automatic op(
      input int rs, rt, rd,
      input bit ld = 0, br = 0
   );
      tick(0, 1, rs, rt, 1, 1, rd, 1, ld, br);
   endtask

   task automatic nop(input int n = 1);
      repeat (n) tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: every cycle presents a full output set.
   initial begin
      obs_t e, g;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            g.pc   = bus.pc_en;
            g.ifid = bus.ifid_en;
            g.bub  = bus.idex_bubble;
            g.fl   = bus.ifid_flush;
            g.frz  = bus.mem_freeze;
            g.brs  = bus.id_rs_byp;
            g.brt  = bus.id_rt_byp;
            g.frs  = bus.fwd_rs_sel;
            g.frt  = bus.fwd_rt_sel;
`ifdef HAZARD_PERF_CNT_EN
            g.sc = bus.stall_cnt;
            g.fc = bus.flush_cnt;
`else
            g.sc = '0;
            g.fc = '0;
`endif
            checks++;
            cyc++;
            if (g !== e) begin
               errors++;
               $display(
                 "FAIL outputs cyc=%0d got pc/ifid/bub/fl/frz/brs/brt=%b%b%b%b%b%b%b frs=%0d frt=%0d sc=%0d fc=%0d want %b%b%b%b%b%b%b frs=%0d frt=%0d sc=%0d fc=%0d",
                 cyc, g.pc, g.ifid, g.bub, g.fl, g.frz,
                 g.brs, g.brt, g.frs, g.frt, g.sc, g.fc,
                 e.pc, e.ifid, e.bub, e.fl, e.frz,
                 e.brs, e.brt, e.frs, e.frt, e.sc, e.fc);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      bus.id_valid = 0; bus.id_rs = 0;
      bus.id_rt = 0; bus.id_use_rs = 0;
      bus.id_use_rt = 0; bus.id_rd = 0;
      bus.id_we = 0; bus.id_is_load = 0;
      bus.ex_branch_taken = 0;
      model_reset();
      repeat (3) @(posedge clk);
      nop(2);
      // ALU chain: distance 1, 2, 3
      op(1, 2, 3); op(3, 5, 4); nop(3);
      op(1, 2, 3); nop(); op(3, 5, 4); nop(3);
      op(1, 2, 3); nop(2); op(3, 5, 4); nop(3);
      // load-use, then re-presented consumer
      op(9, 9, 2, 1); op(2, 2, 6); op(2, 2, 6);
      nop(8);
      // r0 producer
      op(1, 1, 0); op(0, 0, 7); nop(3);
      // branch over a load-use consumer
      op(9, 9, 2, 1); op(2, 2, 6, 0, 1);
      nop(8);
      // reset during second freeze cycle
      op(9, 9, 2, 1); nop(3);
      tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nop(4);
      // randomized traffic on a small register set
      repeat (3000) begin
         tick($urandom_range(199) == 0,
              $urandom_range(9) != 0,
              $urandom_range(3), $urandom_range(3),
              $urandom_range(9) < 7,
              $urandom_range(9) < 7,
              $urandom_range(3),
              $urandom_range(9) < 8,
              $urandom_range(9) < 3,
              $urandom_range(9) == 0);
      end
      nop(2);
      repeat (2) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d pending, want 0",
                  q.size());
      end
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
